// File: rtl/ppu_pkg.sv
// Shared PPU definitions: register indices, OAM address width and attribute mask.
package ppu_pkg;

  localparam int         OAM_AW      = 8;
  localparam logic [2:0] REG_OAMADDR = 3'd3;
  localparam logic [2:0] REG_OAMDATA = 3'd4;
  localparam logic [7:0] ATTR_MASK   = 8'hE3;

  // While rendering, an OAMDATA write bumps only the sprite index (bits 7:2).
  function automatic logic [7:0] next_sprite_addr(input logic [7:0] addr);
    return {addr[7:2] + 6'd1, addr[1:0]};
  endfunction

endpackage

// File: rtl/oam_ram.sv
// 256x8 OAM array: one write port, async CPU read, registered sprite-evaluation read.
module oam_ram
  import ppu_pkg::*;
#(
  parameter int DEPTH = 256
) (
  input  logic              sysclk,
  input  logic              reset,
  input  logic              we,
  input  logic [OAM_AW-1:0] waddr,
  input  logic [7:0]        wdata,
  input  logic [OAM_AW-1:0] raddr,
  output logic [7:0]        rdata,
  input  logic              eval_rd,
  input  logic [OAM_AW-1:0] eval_addr,
  output logic [7:0]        eval_data
);

  logic [7:0] mem_r [DEPTH];

  // Array write; contents are deliberately not reset.
  always_ff @(posedge sysclk) begin
    if (we) begin
      mem_r[waddr] <= wdata;
    end
  end

  assign rdata = mem_r[raddr];

  // Eval read register; non-blocking update gives read-before-write on collisions.
  always_ff @(posedge sysclk) begin
    if (reset) begin
      eval_data <= 8'h00;
    end else if (eval_rd) begin
      eval_data <= mem_r[eval_addr];
    end else begin
      eval_data <= eval_data;
    end
  end

endmodule

// File: rtl/ppu_oam.sv
// OAMADDR/OAMDATA register logic around the OAM array.
// Optional build macro OAM_ATTR_MASK_EN clears bits 4:2 of stored attribute bytes.
module ppu_oam
  import ppu_pkg::*;
#(
  parameter int OAM_DEPTH = 256
) (
  input  logic       sysclk,
  input  logic       reset,
  input  logic       cpu_clock,
  input  logic       ppu_cs,
  input  logic [2:0] reg_addr,
  input  logic [7:0] reg_datain,
  input  logic       reg_wr,
  input  logic       reg_rd,
  output logic [7:0] reg_dataout,
  input  logic       rendering,
  input  logic       oamaddr_clr,
  input  logic [7:0] eval_addr,
  input  logic       eval_rd,
  output logic [7:0] eval_data
);

  logic [7:0] oam_addr_r;
  logic       wr_s;
  logic       rd_s;
  logic       addr_wr_s;
  logic       data_wr_s;
  logic       data_rd_s;
  logic       ram_we_s;
  logic [7:0] ram_wdata_s;
  logic [7:0] ram_rdata_s;

  assign wr_s      = ppu_cs & reg_wr & cpu_clock;
  assign rd_s      = ppu_cs & reg_rd & cpu_clock;
  assign addr_wr_s = wr_s & (reg_addr == REG_OAMADDR);
  assign data_wr_s = wr_s & (reg_addr == REG_OAMDATA);
  assign data_rd_s = rd_s & (reg_addr == REG_OAMDATA);
  assign ram_we_s  = data_wr_s & ~rendering & ~reset;

  // Write data, with optional attribute-byte masking on every write path.
  always_comb begin
    ram_wdata_s = reg_datain;
`ifdef OAM_ATTR_MASK_EN
    if (oam_addr_r[1:0] == 2'd2) begin
      ram_wdata_s = reg_datain & ATTR_MASK;
    end else begin
      ram_wdata_s = reg_datain;
    end
`endif
  end

  // OAMADDR: the timing clear wins over any CPU/DMA update in the same cycle.
  always_ff @(posedge sysclk) begin
    if (reset) begin
      oam_addr_r <= 8'h00;
    end else if (cpu_clock && oamaddr_clr) begin
      oam_addr_r <= 8'h00;
    end else if (addr_wr_s) begin
      oam_addr_r <= reg_datain;
    end else if (data_wr_s && !rendering) begin
      oam_addr_r <= oam_addr_r + 8'd1;
    end else if (data_wr_s && rendering) begin
      oam_addr_r <= next_sprite_addr(oam_addr_r);
    end else begin
      oam_addr_r <= oam_addr_r;
    end
  end

  // OAMDATA read mux: rendering exposes the evaluation bus instead of the array.
  always_comb begin
    reg_dataout = 8'h00;
    if (reset) begin
      reg_dataout = 8'h00;
    end else if (data_rd_s) begin
      if (rendering) begin
        reg_dataout = eval_data;
      end else begin
        reg_dataout = ram_rdata_s;
      end
    end else begin
      reg_dataout = 8'h00;
    end
  end

  oam_ram #(
    .DEPTH(OAM_DEPTH)
  ) u_oam_ram (
    .sysclk    (sysclk),
    .reset     (reset),
    .we        (ram_we_s),
    .waddr     (oam_addr_r),
    .wdata     (ram_wdata_s),
    .raddr     (oam_addr_r),
    .rdata     (ram_rdata_s),
    .eval_rd   (eval_rd),
    .eval_addr (eval_addr),
    .eval_data (eval_data)
  );

endmodule

// File: tb/tb_ppu_oam.sv
// Directed self-checking bench for ppu_oam; honours OAM_ATTR_MASK_EN when defined.
module tb_ppu_oam;

  logic       sysclk = 1'b0;
  logic       reset = 1'b1;
  logic       cpu_clock = 1'b0;
  logic       ppu_cs = 1'b0;
  logic [2:0] reg_addr = 3'd0;
  logic [7:0] reg_datain = 8'h00;
  logic       reg_wr = 1'b0;
  logic       reg_rd = 1'b0;
  logic [7:0] reg_dataout;
  logic       rendering = 1'b0;
  logic       oamaddr_clr = 1'b0;
  logic [7:0] eval_addr = 8'h00;
  logic       eval_rd = 1'b0;
  logic [7:0] eval_data;

  int nvec = 0;
  int nerr = 0;
  logic [7:0] mdl [256];

  ppu_oam #(.OAM_DEPTH(256)) dut (
    .sysclk(sysclk), .reset(reset), .cpu_clock(cpu_clock), .ppu_cs(ppu_cs),
    .reg_addr(reg_addr), .reg_datain(reg_datain), .reg_wr(reg_wr), .reg_rd(reg_rd),
    .reg_dataout(reg_dataout), .rendering(rendering), .oamaddr_clr(oamaddr_clr),
    .eval_addr(eval_addr), .eval_rd(eval_rd), .eval_data(eval_data)
  );

  always #5 sysclk = ~sysclk;

  function automatic logic [7:0] stored(input logic [7:0] a, input logic [7:0] d);
`ifdef OAM_ATTR_MASK_EN
    if (a[1:0] == 2'd2) return d & 8'hE3;
`endif
    return d;
  endfunction

  task automatic mdl_wr(input logic [7:0] a, input logic [7:0] d);
    mdl[a] = stored(a, d);
  endtask

  task automatic cpu_write(input logic [2:0] a, input logic [7:0] d);
    @(negedge sysclk);
    ppu_cs = 1'b1; reg_addr = a; reg_datain = d; reg_wr = 1'b1; cpu_clock = 1'b1;
    @(negedge sysclk);
    ppu_cs = 1'b0; reg_wr = 1'b0; cpu_clock = 1'b0;
  endtask

  task automatic cpu_read(output logic [7:0] v);
    @(negedge sysclk);
    ppu_cs = 1'b1; reg_addr = 3'd4; reg_rd = 1'b1; cpu_clock = 1'b1;
    #1 v = reg_dataout;
    #1 ppu_cs = 1'b0; reg_rd = 1'b0; cpu_clock = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (3) @(negedge sysclk);
    nvec++;
    if (eval_data !== 8'h00) begin
      $display("FAIL reset_eval: got %h expected 00", eval_data); nerr++;
    end
    nvec++;
    if (reg_dataout !== 8'h00) begin
      $display("FAIL reset_dataout: got %h expected 00", reg_dataout); nerr++;
    end
    reset = 1'b0;
  endtask

  task automatic test_dma;
    logic [7:0] v;
    cpu_write(3'd3, 8'h80);
    @(negedge sysclk);
    ppu_cs = 1'b1; reg_addr = 3'd4; reg_wr = 1'b1; cpu_clock = 1'b1;
    for (int i = 0; i < 256; i++) begin
      reg_datain = i[7:0];
      mdl_wr(8'h80 + i[7:0], i[7:0]);
      @(negedge sysclk);
    end
    ppu_cs = 1'b0; reg_wr = 1'b0; cpu_clock = 1'b0;
    cpu_read(v);
    nvec++;
    if (v !== 8'h00) begin
      $display("FAIL dma_final_addr: got %h expected 00 (mem[80])", v); nerr++;
    end
    for (int a = 0; a < 256; a++) begin
      cpu_write(3'd3, a[7:0]);
      cpu_read(v);
      nvec++;
      if (v !== mdl[a]) begin
        $display("FAIL dma_fill[%02h]: got %h expected %h", a, v, mdl[a]); nerr++;
      end
    end
  endtask

  task automatic test_basic;
    logic [7:0] v;
    cpu_write(3'd3, 8'h10);
    cpu_write(3'd4, 8'hAA); mdl_wr(8'h10, 8'hAA);
    cpu_write(3'd4, 8'hBB); mdl_wr(8'h11, 8'hBB);
    cpu_read(v);
    nvec++;
    if (v !== mdl[8'h12]) begin
      $display("FAIL basic_addr12: got %h expected %h", v, mdl[8'h12]); nerr++;
    end
    cpu_read(v);
    nvec++;
    if (v !== mdl[8'h12]) begin
      $display("FAIL read_no_inc: got %h expected %h", v, mdl[8'h12]); nerr++;
    end
    cpu_write(3'd3, 8'h10);
    cpu_read(v);
    nvec++;
    if (v !== 8'hAA) begin
      $display("FAIL basic_mem10: got %h expected aa", v); nerr++;
    end
    cpu_write(3'd3, 8'h11);
    cpu_read(v);
    nvec++;
    if (v !== 8'hBB) begin
      $display("FAIL basic_mem11: got %h expected bb", v); nerr++;
    end
  endtask

  task automatic test_wrap;
    logic [7:0] v;
    cpu_write(3'd3, 8'hFF);
    cpu_write(3'd4, 8'h3C); mdl_wr(8'hFF, 8'h3C);
    cpu_read(v);
    nvec++;
    if (v !== mdl[8'h00]) begin
      $display("FAIL wrap_addr00: got %h expected %h", v, mdl[8'h00]); nerr++;
    end
  endtask

  task automatic test_attr;
    logic [7:0] v;
    logic [7:0] exp;
`ifdef OAM_ATTR_MASK_EN
    exp = 8'hE3;
`else
    exp = 8'hFF;
`endif
    cpu_write(3'd3, 8'h02);
    cpu_write(3'd4, 8'hFF); mdl[8'h02] = exp;
    cpu_write(3'd3, 8'h02);
    cpu_read(v);
    nvec++;
    if (v !== exp) begin
      $display("FAIL attr_mask: got %h expected %h", v, exp); nerr++;
    end
  endtask

  task automatic test_eval;
    @(negedge sysclk);
    eval_addr = 8'h20; eval_rd = 1'b1;
    @(negedge sysclk);
    eval_rd = 1'b0; eval_addr = 8'h33;
    nvec++;
    if (eval_data !== mdl[8'h20]) begin
      $display("FAIL eval_read: got %h expected %h", eval_data, mdl[8'h20]); nerr++;
    end
    @(negedge sysclk);
    nvec++;
    if (eval_data !== mdl[8'h20]) begin
      $display("FAIL eval_hold: got %h expected %h", eval_data, mdl[8'h20]); nerr++;
    end
  endtask

  task automatic test_rendering;
    logic [7:0] v;
    rendering = 1'b1;
    cpu_write(3'd3, 8'h05);
    cpu_write(3'd4, 8'h77);
    cpu_read(v);
    nvec++;
    if (v !== mdl[8'h20]) begin
      $display("FAIL render_read_eval: got %h expected %h", v, mdl[8'h20]); nerr++;
    end
    rendering = 1'b0;
    cpu_read(v);
    nvec++;
    if (v !== mdl[8'h09]) begin
      $display("FAIL render_addr09: got %h expected %h", v, mdl[8'h09]); nerr++;
    end
    cpu_write(3'd3, 8'h05);
    cpu_read(v);
    nvec++;
    if (v !== mdl[8'h05]) begin
      $display("FAIL render_no_write: got %h expected %h", v, mdl[8'h05]); nerr++;
    end
  endtask

  task automatic test_clr;
    logic [7:0] v;
    oamaddr_clr = 1'b1;
    cpu_write(3'd3, 8'h40);
    oamaddr_clr = 1'b0;
    cpu_read(v);
    nvec++;
    if (v !== mdl[8'h00]) begin
      $display("FAIL clr_vs_2003: got %h expected %h", v, mdl[8'h00]); nerr++;
    end
    cpu_write(3'd3, 8'h30);
    oamaddr_clr = 1'b1;
    cpu_write(3'd4, 8'h5E); mdl_wr(8'h30, 8'h5E);
    oamaddr_clr = 1'b0;
    cpu_read(v);
    nvec++;
    if (v !== mdl[8'h00]) begin
      $display("FAIL clr_vs_2004_addr: got %h expected %h", v, mdl[8'h00]); nerr++;
    end
    cpu_write(3'd3, 8'h30);
    cpu_read(v);
    nvec++;
    if (v !== 8'h5E) begin
      $display("FAIL clr_vs_2004_mem: got %h expected 5e", v); nerr++;
    end
  endtask

  task automatic test_gating;
    logic [7:0] v;
    cpu_write(3'd3, 8'h44);
    @(negedge sysclk);
    ppu_cs = 1'b1; reg_addr = 3'd3; reg_datain = 8'h55; reg_wr = 1'b1; cpu_clock = 1'b0;
    @(negedge sysclk);
    ppu_cs = 1'b0; reg_wr = 1'b0;
    cpu_read(v);
    nvec++;
    if (v !== mdl[8'h44]) begin
      $display("FAIL gate_cpu_clock: got %h expected %h", v, mdl[8'h44]); nerr++;
    end
    @(negedge sysclk);
    ppu_cs = 1'b0; reg_addr = 3'd4; reg_rd = 1'b1; cpu_clock = 1'b1;
    #1 v = reg_dataout;
    #1 reg_rd = 1'b0; cpu_clock = 1'b0;
    nvec++;
    if (v !== 8'h00) begin
      $display("FAIL unqualified_read: got %h expected 00", v); nerr++;
    end
  endtask

  task automatic test_back_to_back;
    logic [7:0] old;
    old = mdl[8'h20];
    cpu_write(3'd3, 8'h20);
    @(negedge sysclk);
    ppu_cs = 1'b1; reg_addr = 3'd4; reg_datain = 8'hC7; reg_wr = 1'b1; cpu_clock = 1'b1;
    eval_addr = 8'h20; eval_rd = 1'b1;
    @(negedge sysclk);
    ppu_cs = 1'b0; reg_wr = 1'b0; cpu_clock = 1'b0; eval_rd = 1'b0;
    mdl_wr(8'h20, 8'hC7);
    nvec++;
    if (eval_data !== old) begin
      $display("FAIL rbw_old: got %h expected %h", eval_data, old); nerr++;
    end
    eval_rd = 1'b1;
    @(negedge sysclk);
    eval_rd = 1'b0;
    nvec++;
    if (eval_data !== 8'hC7) begin
      $display("FAIL rbw_new: got %h expected c7", eval_data); nerr++;
    end
  endtask

  task automatic test_reset_dma;
    logic [7:0] v;
    cpu_write(3'd3, 8'h60);
    @(negedge sysclk);
    ppu_cs = 1'b1; reg_addr = 3'd4; reg_wr = 1'b1; cpu_clock = 1'b1;
    for (int i = 0; i < 3; i++) begin
      reg_datain = 8'hD0 + i[7:0];
      mdl_wr(8'h60 + i[7:0], 8'hD0 + i[7:0]);
      @(negedge sysclk);
    end
    reg_datain = 8'hEE; reset = 1'b1;
    @(negedge sysclk);
    reg_wr = 1'b0; reg_rd = 1'b1;
    #1 v = reg_dataout;
    nvec++;
    if (v !== 8'h00) begin
      $display("FAIL rst_dataout: got %h expected 00", v); nerr++;
    end
    nvec++;
    if (eval_data !== 8'h00) begin
      $display("FAIL rst_eval: got %h expected 00", eval_data); nerr++;
    end
    #1 reg_rd = 1'b0; reset = 1'b0; reg_wr = 1'b1; reg_datain = 8'hC1;
    mdl_wr(8'h00, 8'hC1);
    @(negedge sysclk);
    ppu_cs = 1'b0; reg_wr = 1'b0; cpu_clock = 1'b0;
    cpu_read(v);
    nvec++;
    if (v !== mdl[8'h01]) begin
      $display("FAIL rst_restart_addr: got %h expected %h", v, mdl[8'h01]); nerr++;
    end
    cpu_write(3'd3, 8'h00);
    cpu_read(v);
    nvec++;
    if (v !== 8'hC1) begin
      $display("FAIL rst_restart_mem: got %h expected c1", v); nerr++;
    end
    cpu_write(3'd3, 8'h63);
    cpu_read(v);
    nvec++;
    if (v !== mdl[8'h63]) begin
      $display("FAIL rst_dropped_write: got %h expected %h", v, mdl[8'h63]); nerr++;
    end
  endtask

  initial begin
    test_reset;
    test_dma;
    test_basic;
    test_wrap;
    test_attr;
    test_eval;
    test_rendering;
    test_clr;
    test_gating;
    test_back_to_back;
    test_reset_dma;
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
